// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous ROM, resolves next PC.
// Define FETCH_JAL_EN to enable jal support (jump input and link_pc).
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   output logic [PC_W-1:0] rom_addr,
   input  logic [31:0]     rom_data,
   output logic [31:0]     instr,
   output logic            instr_valid,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] link_pc,
   input  logic            branch,
   input  logic            jump,
   input  logic            zero,
   input  logic [31:0]     imm,
   output logic            halted,
   output logic            misalign
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]      state;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     instr_q;
   logic            halted_q;
   logic            misalign_q;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] target;
   logic            cond;
   logic            taken;
   logic            unused_in;

   // imm is a halfword offset; bit 0 of the byte offset is implied zero
   assign pc_inc = pc_q + PC_W'(3'd4);
   assign offset = {imm[PC_W-2:0], 1'b0};
   assign target = pc_q + offset;
   assign cond   = branch & (instr_q[12] ^ zero);

`ifdef FETCH_JAL_EN
   assign taken     = jump | cond;
   assign link_pc   = pc_inc;
   assign unused_in = ^imm[31:PC_W-1];
`else
   assign taken     = cond;
   assign link_pc   = '0;
   assign unused_in = ^{imm[31:PC_W-1], jump};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         unique case (state)
            S_FETCH: state <= S_WAIT;
            S_WAIT: begin
               instr_q <= rom_data;
               if (rom_data == 32'd0) begin
                  state    <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  if (taken && target[1]) begin
                     misalign_q <= 1'b1;
                     state      <= S_HALT;
                  end else begin
                     pc_q  <= taken ? target : pc_inc;
                     state <= S_FETCH;
                  end
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   assign rom_addr    = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state == S_EXEC);
   assign halted      = halted_q;
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for next-PC resolution,
// plus hand sequences for program flow, stall and asynchronous reset.
module tb_fetch_unit;

`ifdef FETCH_JAL_EN
   localparam bit JAL = 1'b1;
`else
   localparam bit JAL = 1'b0;
`endif

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] BEQ = 32'h0020_8463;
   localparam logic [31:0] BNE = 32'h0020_9463;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic [7:0]  pc;
   logic [7:0]  link_pc;
   logic        branch = 1'b0;
   logic        jump = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] imm = 32'd0;
   logic        halted;
   logic        misalign;

   logic [31:0] mem [64];

   int total = 0;
   int bad = 0;

   fetch_unit #(.PC_W(8), .RESET_PC(8'd0)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .instr(instr), .instr_valid(instr_valid),
      .pc(pc), .link_pc(link_pc),
      .branch(branch), .jump(jump), .zero(zero), .imm(imm),
      .halted(halted), .misalign(misalign)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= mem[rom_addr[7:2]];

   typedef struct {
      string       name;
      logic [31:0] word;
      logic [7:0]  at;
      logic        br;
      logic        jp;
      logic        z;
      logic [31:0] imm;
      logic [7:0]  nxt;
      logic        mis;
   } vec_t;

   vec_t v [9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 64; i++) mem[i] = NOP;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_to(input logic [7:0] target, output bit found);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (instr_valid && pc == target) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit found;
      logic [31:0] prog [4];
      int valid_run;

      v[0] = '{"beq_t",   BEQ, 8'd8,   1, 0, 1, 32'd8,        8'd24,  0};
      v[1] = '{"beq_nt",  BEQ, 8'd8,   1, 0, 0, 32'd8,        8'd12,  0};
      v[2] = '{"bne_nt",  BNE, 8'd8,   1, 0, 1, 32'd8,        8'd12,  0};
      v[3] = '{"bne_t",   BNE, 8'd16,  1, 0, 0, 32'hFFFFFFFC, 8'd8,   0};
      v[4] = '{"mis",     BEQ, 8'd4,   1, 0, 1, 32'd1,        8'd4,   1};
      v[5] = '{"jal",     NOP, 8'd4,   0, 1, 0, 32'd6,
               JAL ? 8'd16 : 8'd8, 0};
      v[6] = '{"wrap4",   NOP, 8'd252, 0, 0, 0, 32'd0,        8'd0,   0};
      v[7] = '{"tgtwrap", BEQ, 8'd8,   1, 0, 1, 32'hFFFFFFF8, 8'd248, 0};
      v[8] = '{"nobr",    BNE, 8'd4,   0, 0, 0, 32'd8,        8'd8,   0};

      // reset values
      fill_nop();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_link", link_pc, JAL ? 32'd4 : 32'd0);
      chk("rst_halt", halted, 0);
      chk("rst_mis", misalign, 0);

      // sequential program ending on the all-zero word
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h00A0_0113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h0000_0000;
      for (int i = 0; i < 4; i++) mem[i] = prog[i];
      do_reset();
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         chk($sformatf("seq_valid%0d", n), instr_valid,
             (n == 3 || n == 6 || n == 9) ? 32'd1 : 32'd0);
         chk($sformatf("seq_halt%0d", n), halted, (n >= 12) ? 32'd1 : 32'd0);
         if (n == 3 || n == 6 || n == 9) begin
            chk($sformatf("seq_pc%0d", n), pc, (n / 3 - 1) * 4);
            chk($sformatf("seq_ins%0d", n), instr, prog[n / 3 - 1]);
         end
      end
      chk("seq_haltpc", rom_addr, 12);

      // next-PC vector table
      foreach (v[k]) begin
         fill_nop();
         mem[v[k].at[7:2]] = v[k].word;
         do_reset();
         run_to(v[k].at, found);
         chk({v[k].name, "_reach"}, found, 1);
         chk({v[k].name, "_link"}, link_pc, JAL ? 32'(v[k].at + 8'd4) : 32'd0);
         branch = v[k].br;
         jump   = v[k].jp;
         zero   = v[k].z;
         imm    = v[k].imm;
         @(posedge clk);
         #1;
         branch = 1'b0;
         jump   = 1'b0;
         zero   = 1'b0;
         imm    = 32'd0;
         chk({v[k].name, "_pc"}, pc, v[k].nxt);
         chk({v[k].name, "_addr"}, rom_addr, v[k].nxt);
         chk({v[k].name, "_mis"}, misalign, v[k].mis);
         chk({v[k].name, "_valid"}, instr_valid, 0);
         if (v[k].mis) begin
            repeat (4) @(negedge clk);
            chk({v[k].name, "_stay"}, instr_valid, 0);
            chk({v[k].name, "_haltpc"}, pc, v[k].at);
            chk({v[k].name, "_halted"}, halted, 0);
         end
      end

      // stall in EXEC at pc 4, stall ignored in FETCH/WAIT
      fill_nop();
      mem[1] = 32'h0010_0113;
      do_reset();
      run_to(8'd4, found);
      chk("stall_reach", found, 1);
      valid_run = 0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 2) stall = 1'b0;
         if (instr_valid) valid_run++;
         chk($sformatf("stall_pc%0d", i), pc, 4);
         chk($sformatf("stall_ins%0d", i), instr, 32'h0010_0113);
      end
      chk("stall_cnt", valid_run, 3);
      @(negedge clk);
      chk("stall_fetch_v", instr_valid, 0);
      chk("stall_fetch_a", rom_addr, 8);
      stall = 1'b1;
      @(negedge clk);
      @(negedge clk);
      stall = 1'b0;
      chk("stall_next_v", instr_valid, 1);
      chk("stall_next_pc", pc, 8);

      // asynchronous reset during EXEC at pc 8
      run_to(8'd8, found);
      chk("arst_reach", found, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 0);
      chk("arst_addr", rom_addr, 0);
      chk("arst_instr", instr, 0);
      chk("arst_valid", instr_valid, 0);
      chk("arst_link", link_pc, JAL ? 32'd4 : 32'd0);
      chk("arst_halt", halted, 0);
      chk("arst_mis", misalign, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         chk($sformatf("arst_v%0d", n), instr_valid, (n == 3) ? 32'd1 : 32'd0);
      end
      chk("arst_restart_pc", pc, 0);
      chk("arst_restart_ins", instr, NOP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
